// File: rtl/imem_loader.sv
// Instruction-memory front end for the mips core: clears a 256x9 RAM, loads a program
// over a valid/ready stream, then releases the core and serves inst = mem[pc].
module imem_loader #(
  parameter int DEPTH = 256,
  parameter int IW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [IW-1:0] load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic [7:0]    pc,
  output logic [IW-1:0] inst,
  output logic          core_rst,
  output logic          load_done,
  output logic          load_err,
  output logic [8:0]    load_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [7:0]    ptr_q, ptr_d;
  logic [8:0]    count_q, count_d;
  logic          err_q, err_d;
  logic          mem_we;
  logic [IW-1:0] mem_wdata;
  logic [IW-1:0] mem_q [DEPTH];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (load_start) begin
          state_d = S_CLEAR;
          ptr_d   = 8'd0;
          count_d = 9'd0;
          err_d   = 1'b0;
        end
      end
      S_CLEAR: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + 8'd1;
        if (ptr_q == 8'hFF) state_d = S_LOAD;
      end
      S_LOAD: begin
        // ready is 1 for the whole LOAD state, so valid alone means accept
        if (load_valid) begin
          mem_we    = 1'b1;
          mem_wdata = load_data;
          ptr_d     = ptr_q + 8'd1;
          count_d   = count_q + 9'd1;
          if (load_last || ptr_q == 8'hFF) begin
            state_d = S_RUN;
            err_d   = !load_last;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 8'd0;
      count_q <= 9'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // RAM has no reset; CLEAR guarantees unwritten words read as zero
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[ptr_q] <= mem_wdata;
  end

  assign load_ready = (state_q == S_LOAD);
  assign core_rst   = (state_q != S_RUN);
  assign load_done  = (state_q == S_RUN);
  assign load_err   = err_q;
  assign load_count = count_q;
  assign inst       = (state_q == S_RUN) ? mem_q[pc] : '0;

endmodule
